// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_bmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_bmask,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_bmask,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns load/store instructions into single
// requests on the data-memory bus, waits for the ack (bounded by MAX_WAIT),
// and presents the load result or pass-through value to writeback.
module mem_access_stage #(
  parameter real DELAY    = 0.05,
  parameter int  MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        MemALUOut,
  input  logic [63:0]        MemDb,
  input  logic               MemValid,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemByte,
  mem_access_stage_if.master dmem,
  output logic [63:0]        MemOut,
  output logic               MemStall,
  output logic               MemDone,
  output logic               MemMisaligned,
  output logic               MemBusErr
);

  // DELAY only matters for gate primitives; this block has none, so only
  // sanity-check it at elaboration.
  if (DELAY < 0.0) begin : g_delay_check
    $error("mem_access_stage: DELAY must be non-negative");
  end

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LastWait = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      bmask_q, bmask_d;
  logic            we_q, we_d;
  logic            byte_q, byte_d;
  logic [2:0]      lane_q, lane_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [63:0]     cap_q, cap_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;

  logic            access_s;
  logic            misalign_s;
  logic            aligned_s;
  logic [7:0]      bmask_s;
  logic [63:0]     wdata_s;
  logic [63:0]     lane_shift_s;
  logic [63:0]     load_data_s;

  assign access_s   = MemValid & (MemRead | MemWrite);
  assign misalign_s = access_s & ~MemByte & (MemALUOut[2:0] != 3'b000);
  assign aligned_s  = access_s & ~misalign_s;

  // Byte enables and lane-replicated write data for the incoming access.
  always_comb begin
    bmask_s = 8'hFF;
    wdata_s = MemDb;
    if (MemByte) begin
      bmask_s = 8'h01 << MemALUOut[2:0];
      wdata_s = {8{MemDb[7:0]}};
    end else begin
      bmask_s = 8'hFF;
      wdata_s = MemDb;
    end
  end

  // Select the addressed byte lane (zero-extended) or the whole doubleword.
  assign lane_shift_s = dmem.dmem_rdata >> {lane_q, 3'b000};
  always_comb begin
    load_data_s = dmem.dmem_rdata;
    if (byte_q) begin
      load_data_s = {56'd0, lane_shift_s[7:0]};
    end else begin
      load_data_s = dmem.dmem_rdata;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      bmask_q <= 8'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= 3'd0;
      wait_q  <= '0;
      cap_q   <= 64'd0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      lane_q  <= lane_d;
      wait_q  <= wait_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  // Next-state logic: launch, wait for ack or timeout, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    we_d    = we_q;
    byte_d  = byte_q;
    lane_d  = lane_q;
    wait_d  = wait_q;
    cap_d   = cap_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        if (aligned_s) begin
          state_d = REQ;
          addr_d  = {MemALUOut[63:3], 3'b000};
          wdata_d = wdata_s;
          bmask_d = bmask_s;
          we_d    = MemWrite;
          byte_d  = MemByte;
          lane_d  = MemALUOut[2:0];
          wait_d  = '0;
        end else if (misalign_s) begin
          mis_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (dmem.dmem_ack) begin
          state_d = DONE;
          cap_d   = we_q ? 64'd0 : load_data_s;
        end else if (wait_q == LastWait) begin
          state_d = DONE;
          cap_d   = 64'd0;
          berr_d  = 1'b1;
        end else begin
          wait_d = wait_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pipeline-facing outputs: stall and the value handed to writeback.
  always_comb begin
    MemStall = 1'b0;
    MemOut   = MemALUOut;
    case (state_q)
      IDLE: begin
        MemStall = aligned_s;
        if (misalign_s && !MemWrite) begin
          MemOut = 64'd0;
        end else begin
          MemOut = MemALUOut;
        end
      end
      REQ: begin
        MemStall = 1'b1;
        MemOut   = MemALUOut;
      end
      DONE: begin
        MemStall = 1'b0;
        MemOut   = we_q ? MemALUOut : cap_q;
      end
      default: begin
        MemStall = 1'b0;
        MemOut   = MemALUOut;
      end
    endcase
  end

  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_bmask = bmask_q;
  assign MemDone         = (state_q == DONE);
  assign MemMisaligned   = mis_q;
  assign MemBusErr       = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// aligned accesses checked against a transaction-level expectation model.
module tb_mem_access_stage;
  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] MemALUOut, MemDb, MemOut;
  logic        MemValid, MemRead, MemWrite, MemByte;
  logic        MemStall, MemDone, MemMisaligned, MemBusErr;

  int total = 0;
  int bad   = 0;
  bit exp_mis  = 1'b0;
  bit exp_berr = 1'b0;

  mem_access_stage_if dmem_if();

  mem_access_stage #(.DELAY(0.05), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .MemALUOut(MemALUOut), .MemDb(MemDb),
    .MemValid(MemValid), .MemRead(MemRead), .MemWrite(MemWrite), .MemByte(MemByte),
    .dmem(dmem_if.master),
    .MemOut(MemOut), .MemStall(MemStall), .MemDone(MemDone),
    .MemMisaligned(MemMisaligned), .MemBusErr(MemBusErr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One complete aligned access. delay = ack cycle index within REQ, or -1 for no ack.
  task automatic do_access(input bit is_byte, input bit is_write, input logic [63:0] addr,
                           input logic [63:0] db, input int delay, input logic [63:0] rdata);
    logic [63:0] e_addr, e_wdata, e_out;
    logic [7:0]  e_mask;
    int lane, n;
    lane    = int'(addr % 64'd8);
    e_addr  = addr - (addr % 64'd8);
    e_mask  = is_byte ? 8'(1 << lane) : 8'hFF;
    e_wdata = is_byte ? (64'(db[7:0]) * 64'h0101010101010101) : db;
    if (is_write)       e_out = addr;
    else if (delay < 0) e_out = 64'd0;
    else if (is_byte)   e_out = (rdata >> (8 * lane)) & 64'hFF;
    else                e_out = rdata;
    n = (delay < 0) ? MW : delay + 1;

    @(posedge clk); #1;
    MemValid = 1'b1; MemWrite = is_write;
    MemRead  = is_write ? 1'($urandom) : 1'b1;
    MemByte  = is_byte; MemALUOut = addr; MemDb = db;
    dmem_if.dmem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (MemStall !== 1'b1 || dmem_if.dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL launch stall=%b req=%b exp stall=1 req=0", MemStall, dmem_if.dmem_req);
    end

    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dmem_if.dmem_ack   = (i == delay);
      dmem_if.dmem_rdata = (i == delay) ? rdata : {$urandom, $urandom};
      MemDb = {$urandom, $urandom};
      @(negedge clk);
      total++;
      if (dmem_if.dmem_req !== 1'b1 || MemStall !== 1'b1 || MemDone !== 1'b0 ||
          dmem_if.dmem_we !== is_write || dmem_if.dmem_addr !== e_addr ||
          dmem_if.dmem_bmask !== e_mask || dmem_if.dmem_wdata !== e_wdata) begin
        bad++;
        $display("FAIL req_cycle%0d req=%b stall=%b done=%b we=%b addr=%h mask=%h wdata=%h exp req=1 stall=1 done=0 we=%b addr=%h mask=%h wdata=%h",
                 i, dmem_if.dmem_req, MemStall, MemDone, dmem_if.dmem_we, dmem_if.dmem_addr,
                 dmem_if.dmem_bmask, dmem_if.dmem_wdata, is_write, e_addr, e_mask, e_wdata);
      end
    end

    @(posedge clk); #1;
    dmem_if.dmem_ack = 1'b0;
    @(negedge clk);
    if (delay < 0) exp_berr = 1'b1;
    total++;
    if (MemDone !== 1'b1 || MemStall !== 1'b0 || dmem_if.dmem_req !== 1'b0 || MemOut !== e_out) begin
      bad++;
      $display("FAIL done_phase done=%b stall=%b req=%b out=%h exp done=1 stall=0 req=0 out=%h",
               MemDone, MemStall, dmem_if.dmem_req, MemOut, e_out);
    end
    total++;
    if (MemBusErr !== exp_berr || MemMisaligned !== exp_mis) begin
      bad++;
      $display("FAIL flags berr=%b mis=%b exp berr=%b mis=%b", MemBusErr, MemMisaligned, exp_berr, exp_mis);
    end
  endtask

  // One cycle with no access; optionally a stray ack that must be ignored.
  task automatic idle_cycle(input bit stray_ack);
    logic [63:0] v;
    v = {$urandom, $urandom};
    @(posedge clk); #1;
    MemValid = 1'($urandom); MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'($urandom);
    MemALUOut = v; dmem_if.dmem_ack = stray_ack;
    @(negedge clk);
    total++;
    if (MemOut !== v || MemStall !== 1'b0 || dmem_if.dmem_req !== 1'b0 || MemDone !== 1'b0) begin
      bad++;
      $display("FAIL idle out=%h stall=%b req=%b done=%b exp out=%h stall=0 req=0 done=0",
               MemOut, MemStall, dmem_if.dmem_req, MemDone, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MemValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'b0;
    MemALUOut = 64'd0; MemDb = 64'd0; dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (dmem_if.dmem_req !== 1'b0 || dmem_if.dmem_we !== 1'b0 || dmem_if.dmem_addr !== 64'd0 ||
        dmem_if.dmem_wdata !== 64'd0 || dmem_if.dmem_bmask !== 8'd0 || MemDone !== 1'b0 ||
        MemMisaligned !== 1'b0 || MemBusErr !== 1'b0 || MemStall !== 1'b0 || MemOut !== 64'd0) begin
      bad++;
      $display("FAIL reset req=%b we=%b addr=%h wdata=%h mask=%h done=%b mis=%b berr=%b stall=%b out=%h exp all 0",
               dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata,
               dmem_if.dmem_bmask, MemDone, MemMisaligned, MemBusErr, MemStall, MemOut);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 4; i++) idle_cycle(1'b1);
    dmem_if.dmem_ack = 1'b0;
  endtask

  task automatic test_directed();
    do_access(1'b0, 1'b0, 64'h100, 64'h0, 2, 64'h1122334455667788);
    idle_cycle(1'b0);
    do_access(1'b1, 1'b1, 64'h105, 64'hAB, 0, 64'h0);
    idle_cycle(1'b0);
    do_access(1'b1, 1'b0, 64'h203, 64'h0, $urandom_range(0, 4), 64'h00000000F0000000);
    idle_cycle(1'b0);
    do_access(1'b0, 1'b0, 64'h3F8, 64'h0, MW - 1, 64'hCAFEF00D12345678);
  endtask

  task automatic test_random();
    logic [63:0] a;
    bit b;
    for (int i = 0; i < 30; i++) begin
      b = 1'($urandom);
      a = {$urandom, $urandom};
      if (!b) a = a - (a % 64'd8);
      do_access(b, 1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 5),
                {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 64'h4000, {$urandom, $urandom}, 0, 64'h0);
    do_access(1'b1, 1'b0, 64'h4007, 64'h0, 0, 64'h8100000000000000);
    do_access(1'b0, 1'b0, 64'h4008, 64'h0, 1, 64'hDEADBEEF00C0FFEE);
  endtask

  task automatic test_misaligned(input bit is_write);
    logic [63:0] a;
    a = is_write ? 64'h0000_0000_0000_1232 : 64'h104;
    @(posedge clk); #1;
    MemValid = 1'b1; MemRead = ~is_write; MemWrite = is_write; MemByte = 1'b0; MemALUOut = a;
    @(negedge clk);
    total++;
    if (dmem_if.dmem_req !== 1'b0 || MemStall !== 1'b0 || MemOut !== (is_write ? a : 64'd0)) begin
      bad++;
      $display("FAIL misaligned req=%b stall=%b out=%h exp req=0 stall=0 out=%h",
               dmem_if.dmem_req, MemStall, MemOut, is_write ? a : 64'd0);
    end
    exp_mis = 1'b1;
    idle_cycle(1'b1);
    dmem_if.dmem_ack = 1'b0;
    total++;
    if (MemMisaligned !== 1'b1) begin
      bad++;
      $display("FAIL misaligned_flag mis=%b exp 1", MemMisaligned);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b0, 64'h800, 64'h0, -1, 64'h0);
    idle_cycle(1'b1);
    dmem_if.dmem_ack = 1'b0;
    do_access(1'b1, 1'b0, 64'h901, 64'h0, 3, 64'h000000000000AA00);
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    MemValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; MemALUOut = 64'h500;
    dmem_if.dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (dmem_if.dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_req1 req=%b exp 1", dmem_if.dmem_req);
    end
    @(posedge clk); #1;
    reset = 1'b1; MemValid = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 64'h1234;
    exp_mis = 1'b0; exp_berr = 1'b0;
    @(negedge clk);
    total++;
    if (dmem_if.dmem_req !== 1'b0 || MemDone !== 1'b0 || MemStall !== 1'b0 ||
        dmem_if.dmem_addr !== 64'd0 || dmem_if.dmem_we !== 1'b0 ||
        MemMisaligned !== 1'b0 || MemBusErr !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset req=%b done=%b stall=%b addr=%h we=%b mis=%b berr=%b exp all 0",
               dmem_if.dmem_req, MemDone, MemStall, dmem_if.dmem_addr, dmem_if.dmem_we,
               MemMisaligned, MemBusErr);
    end
    for (int i = 0; i < 3; i++) idle_cycle(1'b0);
    do_access(1'b0, 1'b0, 64'h600, 64'h0, 0, 64'h0F0F0F0F0F0F0F0F);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_directed();
    test_random();
    test_back_to_back();
    test_misaligned(1'b0);
    test_misaligned(1'b1);
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
